melody_sequencer: RTL and testbench
===================================

// Module: melody_sequencer
// PURPOSE
//  Plays a song from a note ROM by sequencing the tone generator: fetches one note word, holds it for a fixed number of beats, then moves to the next.
//  Drives note_div, vol_pos and vol_neg of buzzing_ctl in place of the fixed constants used in top; speaker_ctl is unchanged.
//  Start/stop control, a busy status and a done pulse are provided.
// PARAMETERS
//  ADDR_W       6           note ROM address width (64 entries)
//  BEAT_CYCLES  25_000_000  clk_100mhz cycles per beat (0.25 s)
//  GAP_CYCLES   2_500_000   silent cycles after each note; used only with MELODY_GAP_EN
// PORTS
//  clk_100mhz  in   1       system clock, 100 MHz; the only clock
//  rst_n       in   1       reset, asynchronous, active-low
//  start       in   1       1-cycle pulse: play from address 0
//  stop        in   1       1-cycle pulse: abort and silence
//  vol_level   in   3       loudness 0..7
//  note_addr   out  ADDR_W  note ROM address (registered)
//  note_data   in   8       ROM word, valid 1 clk after note_addr: [7:4] pitch, [3:0] beats
//  note_div    out  22      tone divider to buzzing_ctl
//  vol_pos     out  16      positive amplitude to buzzing_ctl
//  vol_neg     out  16      negative amplitude to buzzing_ctl
//  busy        out  1       1 in every state except IDLE
//  done        out  1       1-cycle pulse when the song ends normally (not on stop)
// BEHAVIOUR
//  Reset: state=IDLE, note_addr=0, note_div=382219 (C4), vol_pos=16'h0000, vol_neg=16'h0000, busy=0, done=0. All outputs are registered.
//  Pitch map (100e6/f, rounded):
//   1=382219  2=340530  3=303370  4=286344
//   5=255102  6=227273  7=202478  8=191113
//   0 and 9..15 are rests: note_div holds its previous value and the volume is forced to 0.
//  Volume while sounding: vol_pos={1'b0,vol_level,12'h000}, vol_neg=~vol_pos.
//   Example: level 7 -> 16'h7000 / 16'h8FFF. Level 0 -> 0 / 16'hFFFF.
//   vol_level is re-registered every cycle in PLAY.
//  FSM: IDLE -> FETCH -> LOAD -> PLAY [-> GAP] -> FETCH ... -> DONE -> IDLE.
//   IDLE:  outputs silent. start -> FETCH with note_addr=0.
//   FETCH: 1-cycle wait for ROM latency.
//   LOAD:  capture note_data. beats==0 -> DONE (end marker). Otherwise load counters and go to PLAY.
//          note_div/vol are updated on entry to PLAY, so the first note is audible on the 3rd edge after start is sampled.
//   PLAY:  lasts exactly beats*BEAT_CYCLES cycles (beat counter plus beats down-counter; no multiplier).
//          At expiry: note_addr+1 -> FETCH. If note_addr is already 2**ADDR_W-1, go to DONE instead; the address never wraps.
//   DONE:  silence, done=1 for one cycle -> IDLE. note_addr resets to 0.
//  stop in any non-IDLE state -> IDLE next edge, silent, no done pulse.
//  start and stop in the same cycle: stop wins.
//  start while busy: ignored.
//  rst_n asserted mid-note: outputs return to reset values immediately (asynchronous).
// CONFIGURATION
//  MELODY_GAP_EN defined: after PLAY, enter GAP for GAP_CYCLES cycles.
//   GAP holds note_div and sets the volume to 0, which separates repeated pitches. stop applies in GAP.
//  Not defined: GAP state absent; PLAY goes directly to FETCH (legato).
// STRUCTURE
//  Shared package melody_pkg: pitch-code localparams, PITCH_DIV table function, state encoding, note-word field widths.
//  One sub-module, beat_timer: BEAT_CYCLES prescaler with load/enable/expire. Reused for GAP_CYCLES.
//  The FSM and output registers stay in melody_sequencer. Behavioural ROM model stays in the bench.
// TESTING (BEAT_CYCLES=10, GAP_CYCLES=3)
//  1 ROM {8'h12,8'h51,8'h00}, vol 7, start
//    -> note_div=382219, vol 7000/8FFF for 20 cycles
//    -> then 255102 for 10 cycles
//    -> silence, done pulse 1 cycle, busy=0.
//  2 ROM {8'h02,8'h31,8'h00}
//    -> 20 cycles vol 0/0 with note_div held
//    -> then 303370.
//  3 stop on cycle 5 of a note
//    -> next edge IDLE, vol 0/0, no done. A later start restarts at addr 0.
//  4 start and stop in the same cycle while IDLE -> stays IDLE.
//    start pulse while PLAY -> note_addr unchanged.
//  5 ROM all 8'h11, ADDR_W=2
//    -> 4 notes, done after addr 3, no wrap.
//    rst_n low mid-note -> immediate reset values.
//  6 With MELODY_GAP_EN: 3 silent cycles between two 8'h61 notes.
//    Without it: back-to-back notes with a 2-cycle FETCH/LOAD hold.
//    vol_level changes 7->2 mid-note -> vol_pos=16'h2000 next cycle.

Source files
------------

// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
// Module      : melody_pkg
// Description : Shared definitions for the melody sequencer: note-word field
//               widths, pitch divider constants, the PITCH_DIV lookup, rest
//               detection, volume word builder and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package melody_pkg;

    // Note word layout: [7:4] pitch code, [3:0] beat count
    localparam int PITCH_W = 4;
    localparam int BEATS_W = 4;
    localparam int DIV_W   = 22;
    localparam int VOL_W   = 16;

    // Tone dividers, 100 MHz / f rounded
    localparam logic [DIV_W-1:0] DIV_C4 = 22'd382219;
    localparam logic [DIV_W-1:0] DIV_D4 = 22'd340530;
    localparam logic [DIV_W-1:0] DIV_E4 = 22'd303370;
    localparam logic [DIV_W-1:0] DIV_F4 = 22'd286344;
    localparam logic [DIV_W-1:0] DIV_G4 = 22'd255102;
    localparam logic [DIV_W-1:0] DIV_A4 = 22'd227273;
    localparam logic [DIV_W-1:0] DIV_B4 = 22'd202478;
    localparam logic [DIV_W-1:0] DIV_C5 = 22'd191113;

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_C4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Codes 0 and 9..15 are rests
    function automatic logic pitch_is_rest(input logic [PITCH_W-1:0] code);
        return (code == 4'd0) || (code > 4'd8);
    endfunction

    // Divider for a sounding pitch code; rests never reach the output
    function automatic logic [DIV_W-1:0] PITCH_DIV(input logic [PITCH_W-1:0] code);
        logic [DIV_W-1:0] div;
        case (code)
            4'd1:    div = DIV_C4;
            4'd2:    div = DIV_D4;
            4'd3:    div = DIV_E4;
            4'd4:    div = DIV_F4;
            4'd5:    div = DIV_G4;
            4'd6:    div = DIV_A4;
            4'd7:    div = DIV_B4;
            4'd8:    div = DIV_C5;
            default: div = DIV_C4;
        endcase
        return div;
    endfunction

    // Positive amplitude for a loudness level; the negative one is its inverse
    function automatic logic [VOL_W-1:0] vol_word(input logic [2:0] level);
        return {1'b0, level, 12'h000};
    endfunction

endpackage : melody_pkg
`default_nettype wire

// File: rtl/beat_timer.sv
`default_nettype none
// ============================================================================
// Module      : beat_timer
// Description : Beat prescaler. On load it arms CYCLES-per-beat counting for
//               'beats' beats; while enabled it counts down and raises expire
//               combinationally during the last cycle of the last beat, so an
//               enabled span lasts exactly beats*CYCLES cycles.
// Ports       : clk, rst_n (async active-low), load, beats, enable, expire
// Revision    : 1.0 - initial release
// ============================================================================
module beat_timer
    import melody_pkg::*;
#(
    parameter int CYCLES     = 25_000_000,
    parameter int TIMER_BW   = BEATS_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [TIMER_BW-1:0] beats,
    input  logic                enable,
    output logic                expire
);

    localparam int                CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [TIMER_BW-1:0] r_beats_left;

    assign expire = enable && (r_cnt == '0) && (r_beats_left == TIMER_BW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_beats_left <= '0;
        end else if (load) begin
            r_cnt        <= CNT_LAST;
            r_beats_left <= beats;
        end else if (enable) begin
            if (r_cnt == '0) begin
                // Beat boundary: start the next beat unless this was the last
                if (r_beats_left > TIMER_BW'(1)) begin
                    r_beats_left <= r_beats_left - TIMER_BW'(1);
                    r_cnt        <= CNT_LAST;
                end
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule : beat_timer
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : melody_sequencer
// Description : Plays a song from an external note ROM by driving the tone
//               divider and amplitudes of the buzzer. Each note word is
//               fetched, held for its beat count, then the next is fetched.
//               A word with zero beats, or the last ROM address, ends the song.
// Ports       : clk_100mhz  - system clock
//               rst_n       - asynchronous active-low reset
//               start/stop  - 1-cycle control pulses (stop has priority)
//               vol_level   - loudness 0..7
//               note_addr   - registered ROM address
//               note_data   - ROM word, valid one clock after note_addr
//               note_div    - tone divider
//               vol_pos/neg - amplitudes
//               busy/done   - status and end-of-song pulse
// Config      : MELODY_GAP_EN - insert GAP_CYCLES silent cycles after each
//               note (default build: notes play back to back)
// Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [2:0]        vol_level,
    output logic [ADDR_W-1:0] note_addr,
    input  logic [7:0]        note_data,
    output logic [21:0]       note_div,
    output logic [15:0]       vol_pos,
    output logic [15:0]       vol_neg,
    output logic              busy,
    output logic              done
);

    state_t r_state;
    logic   r_rest;

    logic [PITCH_W-1:0] w_pitch;
    logic [BEATS_W-1:0] w_beats;
    logic               w_last_addr;
    logic               w_play_load;
    logic               w_play_expire;
    logic               w_note_end;

    assign w_pitch     = note_data[7:4];
    assign w_beats     = note_data[3:0];
    assign w_last_addr = (note_addr == {ADDR_W{1'b1}});
    assign w_play_load = (r_state == S_LOAD) && (w_beats != '0) && !stop;

    beat_timer #(
        .CYCLES   (BEAT_CYCLES),
        .TIMER_BW (BEATS_W)
    ) u_beat_timer (
        .clk    (clk_100mhz),
        .rst_n  (rst_n),
        .load   (w_play_load),
        .beats  (w_beats),
        .enable (r_state == S_PLAY),
        .expire (w_play_expire)
    );

`ifdef MELODY_GAP_EN
    logic w_gap_expire;

    // Same prescaler, armed for a single "beat" of GAP_CYCLES
    beat_timer #(
        .CYCLES   (GAP_CYCLES),
        .TIMER_BW (BEATS_W)
    ) u_gap_timer (
        .clk    (clk_100mhz),
        .rst_n  (rst_n),
        .load   (w_play_expire && !stop),
        .beats  (BEATS_W'(1)),
        .enable (r_state == S_GAP),
        .expire (w_gap_expire)
    );

    assign w_note_end = w_gap_expire;
`else
    logic unused_gap_cycles;
    assign unused_gap_cycles = (GAP_CYCLES != 0);

    assign w_note_end = w_play_expire;
`endif

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rest    <= 1'b0;
            note_addr <= '0;
            note_div  <= RESET_DIV;
            vol_pos   <= '0;
            vol_neg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (stop && (r_state != S_IDLE)) begin
                r_state   <= S_IDLE;
                note_addr <= '0;
                vol_pos   <= '0;
                vol_neg   <= '0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            r_state   <= S_FETCH;
                            note_addr <= '0;
                            busy      <= 1'b1;
                        end
                    end

                    S_FETCH: begin
                        r_state <= S_LOAD;
                    end

                    S_LOAD: begin
                        if (w_beats == '0) begin
                            // End marker
                            r_state <= S_DONE;
                            vol_pos <= '0;
                            vol_neg <= '0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_PLAY;
                            r_rest  <= pitch_is_rest(w_pitch);
                            if (pitch_is_rest(w_pitch)) begin
                                // Rest keeps the previous divider, volume off
                                vol_pos <= '0;
                                vol_neg <= '0;
                            end else begin
                                note_div <= PITCH_DIV(w_pitch);
                                vol_pos  <= vol_word(vol_level);
                                vol_neg  <= ~vol_word(vol_level);
                            end
                        end
                    end

                    S_PLAY: begin
                        // Track live volume changes while the note sounds
                        if (r_rest) begin
                            vol_pos <= '0;
                            vol_neg <= '0;
                        end else begin
                            vol_pos <= vol_word(vol_level);
                            vol_neg <= ~vol_word(vol_level);
                        end
`ifdef MELODY_GAP_EN
                        if (w_play_expire) begin
                            r_state <= S_GAP;
                            vol_pos <= '0;
                            vol_neg <= '0;
                        end
`endif
                        if (w_note_end) begin
                            if (w_last_addr) begin
                                r_state <= S_DONE;
                                vol_pos <= '0;
                                vol_neg <= '0;
                                done    <= 1'b1;
                            end else begin
                                r_state   <= S_FETCH;
                                note_addr <= note_addr + ADDR_W'(1);
                            end
                        end
                    end

`ifdef MELODY_GAP_EN
                    S_GAP: begin
                        if (w_note_end) begin
                            if (w_last_addr) begin
                                r_state <= S_DONE;
                                done    <= 1'b1;
                            end else begin
                                r_state   <= S_FETCH;
                                note_addr <= note_addr + ADDR_W'(1);
                            end
                        end
                    end
`endif

                    S_DONE: begin
                        r_state   <= S_IDLE;
                        note_addr <= '0;
                        busy      <= 1'b0;
                    end

                    default: begin
                        r_state   <= S_IDLE;
                        note_addr <= '0;
                        vol_pos   <= '0;
                        vol_neg   <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : melody_sequencer
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_melody_sequencer
// Description : Self-checking bench for melody_sequencer with BEAT_CYCLES=10
//               and GAP_CYCLES=3. Expected waveforms are tables of segments
//               {cycle count, note_div, vol_pos, vol_neg, busy, done}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;

    localparam int ADDR_W = 6;
    localparam int BEAT   = 10;
`ifdef MELODY_GAP_EN
    localparam int GAPN   = 3;
`else
    localparam int GAPN   = 0;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic [2:0]        vol_level;
    logic [ADDR_W-1:0] note_addr;
    logic [7:0]        note_data;
    logic [21:0]       note_div;
    logic [15:0]       vol_pos;
    logic [15:0]       vol_neg;
    logic              busy;
    logic              done;

    logic [7:0] rom [64];

    melody_sequencer #(
        .ADDR_W      (ADDR_W),
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (3)
    ) u_dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .vol_level  (vol_level),
        .note_addr  (note_addr),
        .note_data  (note_data),
        .note_div   (note_div),
        .vol_pos    (vol_pos),
        .vol_neg    (vol_neg),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: one clock of latency
    always @(posedge clk) note_data <= rom[note_addr];

    typedef struct packed {
        int          n;
        logic [21:0] div;
        logic [15:0] vp;
        logic [15:0] vn;
        logic        busy;
        logic        done;
    } seg_t;

    seg_t segs[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic [21:0] pitch_tab [8] = '{22'd382219, 22'd340530, 22'd303370, 22'd286344,
                                   22'd255102, 22'd227273, 22'd202478, 22'd191113};
    int          sweep_codes [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 9, 15};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [21:0] d, input logic [15:0] vp,
                       input logic [15:0] vn, input logic b, input logic dn);
        seg_t s;
        s.n = n; s.div = d; s.vp = vp; s.vn = vn; s.busy = b; s.done = dn;
        segs.push_back(s);
    endtask

    // One note at level 7 followed by its (optional) gap and the FETCH/LOAD hold
    task automatic add_note(input logic [21:0] d, input bit snd, input int beats);
        add(beats * BEAT, d, snd ? 16'h7000 : 16'h0000, snd ? 16'h8FFF : 16'h0000, 1'b1, 1'b0);
        if (GAPN > 0) begin
            add(GAPN, d, 16'h0000, 16'h0000, 1'b1, 1'b0);
            add(2, d, 16'h0000, 16'h0000, 1'b1, 1'b0);
        end else begin
            add(2, d, snd ? 16'h7000 : 16'h0000, snd ? 16'h8FFF : 16'h0000, 1'b1, 1'b0);
        end
    endtask

    task automatic add_end(input logic [21:0] d);
        add(1, d, 16'h0000, 16'h0000, 1'b1, 1'b1);
        add(1, d, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic run_segs(input string name);
        int idx = 0;
        foreach (segs[i]) begin
            for (int k = 0; k < segs[i].n; k++) begin
                compared++;
                if ({note_div, vol_pos, vol_neg, busy, done} !==
                    {segs[i].div, segs[i].vp, segs[i].vn, segs[i].busy, segs[i].done}) begin
                    mismatched++;
                    $display("FAIL %s cyc %0d: got div=%0d vp=%h vn=%h busy=%b done=%b, expected div=%0d vp=%h vn=%h busy=%b done=%b",
                             name, idx, note_div, vol_pos, vol_neg, busy, done,
                             segs[i].div, segs[i].vp, segs[i].vn, segs[i].busy, segs[i].done);
                end
                idx++;
                @(negedge clk);
            end
        end
        segs.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] prev;
        int          cyc;
        bit          got_done;
        bit          wrapped;
        logic [ADDR_W-1:0] prev_addr;

        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        vol_level = 3'd7;
        clear_rom();
        repeat (3) @(negedge clk);

        // Reset values
        chk("reset_div",  {42'd0, note_div}, 64'd382219);
        chk("reset_vpos", {48'd0, vol_pos}, 64'd0);
        chk("reset_vneg", {48'd0, vol_neg}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_addr", {58'd0, note_addr}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pitch sweep: every code with one beat, rests hold the divider
        clear_rom();
        foreach (sweep_codes[i]) rom[i] = {sweep_codes[i][3:0], 4'h1};
        prev = 22'd382219;
        add(2, prev, 16'h0000, 16'h0000, 1'b1, 1'b0);
        foreach (sweep_codes[i]) begin
            if (sweep_codes[i] >= 1 && sweep_codes[i] <= 8) begin
                prev = pitch_tab[sweep_codes[i] - 1];
                add_note(prev, 1'b1, 1);
            end else begin
                add_note(prev, 1'b0, 1);
            end
        end
        add_end(prev);
        pulse_start();
        run_segs("sweep");

        // Two notes then end marker
        clear_rom();
        rom[0] = 8'h12; rom[1] = 8'h51; rom[2] = 8'h00;
        add(2, 22'd191113, 16'h0000, 16'h0000, 1'b1, 1'b0);
        add_note(22'd382219, 1'b1, 2);
        add_note(22'd255102, 1'b1, 1);
        add_end(22'd255102);
        pulse_start();
        run_segs("song1");

        // Rest then a note
        clear_rom();
        rom[0] = 8'h02; rom[1] = 8'h31; rom[2] = 8'h00;
        add(2, 22'd255102, 16'h0000, 16'h0000, 1'b1, 1'b0);
        add_note(22'd255102, 1'b0, 2);
        add_note(22'd303370, 1'b1, 1);
        add_end(22'd303370);
        pulse_start();
        run_segs("rest");

        // Repeated pitch: legato or separated by the gap
        clear_rom();
        rom[0] = 8'h61; rom[1] = 8'h61; rom[2] = 8'h00;
        add(2, 22'd303370, 16'h0000, 16'h0000, 1'b1, 1'b0);
        add_note(22'd227273, 1'b1, 1);
        add_note(22'd227273, 1'b1, 1);
        add_end(22'd227273);
        pulse_start();
        run_segs("repeat");

        // Stop on the 5th cycle of a note, then restart
        clear_rom();
        rom[0] = 8'h11; rom[1] = 8'h11; rom[2] = 8'h00;
        pulse_start();
        repeat (6) @(negedge clk);
        pulse_stop();
        chk("stop_busy", {63'd0, busy}, 64'd0);
        chk("stop_vol",  {32'd0, vol_pos, vol_neg}, 64'd0);
        chk("stop_done", {63'd0, done}, 64'd0);
        got_done = 1'b0;
        repeat (20) begin
            if (done || busy) got_done = 1'b1;
            @(negedge clk);
        end
        chk("stop_no_done", {63'd0, got_done}, 64'd0);
        pulse_start();
        chk("restart_addr", {58'd0, note_addr}, 64'd0);
        chk("restart_busy", {63'd0, busy}, 64'd1);
        repeat (2) @(negedge clk);
        chk("restart_sound", {10'd0, note_div, vol_pos, vol_neg}, {10'd0, 22'd382219, 16'h7000, 16'h8FFF});
        pulse_stop();
        wait_idle("restart_stop_idle");

        // start and stop together while IDLE
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("start_stop_busy_later", {63'd0, busy}, 64'd0);

        // start while playing is ignored
        pulse_start();
        repeat (2) @(negedge clk);
        pulse_start();
        chk("busy_start_addr", {58'd0, note_addr}, 64'd0);
        chk("busy_start_vol",  {48'd0, vol_pos}, 64'h7000);
        repeat (9) @(negedge clk);
        chk("busy_start_next_addr", {58'd0, note_addr}, 64'd1);
        pulse_stop();
        wait_idle("busy_start_idle");

        // Live volume change
        clear_rom();
        rom[0] = 8'h81; rom[1] = 8'h00;
        pulse_start();
        repeat (2) @(negedge clk);
        chk("vol7", {10'd0, note_div, vol_pos, vol_neg}, {10'd0, 22'd191113, 16'h7000, 16'h8FFF});
        vol_level = 3'd2;
        @(negedge clk);
        chk("vol2", {32'd0, vol_pos, vol_neg}, {32'd0, 16'h2000, 16'hDFFF});
        vol_level = 3'd0;
        @(negedge clk);
        chk("vol0", {32'd0, vol_pos, vol_neg}, {32'd0, 16'h0000, 16'hFFFF});
        vol_level = 3'd7;
        pulse_stop();
        wait_idle("vol_idle");

        // Full ROM: plays every address, ends at the last one without wrapping
        for (int i = 0; i < 64; i++) rom[i] = 8'h11;
        pulse_start();
        cyc       = 1;
        got_done  = 1'b0;
        wrapped   = 1'b0;
        prev_addr = '0;
        while (cyc < 3000 && !got_done) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (note_addr < prev_addr) wrapped = 1'b1;
                prev_addr = note_addr;
                @(negedge clk);
                cyc++;
            end
        end
        chk("full_done_seen", {63'd0, got_done}, 64'd1);
        chk("full_no_wrap",   {63'd0, wrapped}, 64'd0);
        chk("full_done_cycle", 64'(cyc), 64'(64 * (12 + GAPN) + 1));
        chk("full_done_addr", {58'd0, note_addr}, 64'd63);
        @(negedge clk);
        chk("full_after_done", {56'd0, busy, done, note_addr}, 64'd0);

        // Asynchronous reset in the middle of a note
        clear_rom();
        rom[0] = 8'h52; rom[1] = 8'h00;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("pre_reset_sound", {10'd0, note_div, vol_pos, vol_neg}, {10'd0, 22'd255102, 16'h7000, 16'h8FFF});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_div", {42'd0, note_div}, 64'd382219);
        chk("async_reset_vol", {32'd0, vol_pos, vol_neg}, 64'd0);
        chk("async_reset_ctl", {56'd0, busy, done, note_addr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_melody_sequencer
`default_nettype wire
